// File: rtl/noc_pkg.sv
// Shared NoC types: the flit record carried to the router and the packet-tracking state.
package noc_pkg;

  // Default field widths of the flit record. The injector's width parameters
  // default to these values; changing the flit layout means editing them here.
  localparam int NOC_DATA_W  = 32;
  localparam int NOC_TDEST_W = 4;
  localparam int NOC_TID_W   = 2;
  localparam int NOC_DEST_W  = NOC_TDEST_W + NOC_TID_W;

  // One flit = one AXI-Stream beat; dest is {tid, tdest}.
  typedef struct packed {
    logic [NOC_DATA_W-1:0] data;
    logic [NOC_DEST_W-1:0] dest;
    logic                  is_tail;
  } flit_t;

  // Packet framing state on the ingress stream.
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/flit_fifo.sv
// Synchronous FIFO with registered read/write pointers (extra wrap bit for full/empty).
module flit_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  // Pointer advance; push into full and pop from empty are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty) rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is not reset: an entry is only read once the pointers say it was written.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axis_flit_injector.sv
// AXI-Stream to NoC local-port injector: ingress FIFO, credit-gated launch,
// packet framing check on {tid, tdest}.
module axis_flit_injector
  import noc_pkg::*;
#(
  parameter int TDATA_WIDTH       = NOC_DATA_W,
  parameter int TDEST_WIDTH       = NOC_TDEST_W,
  parameter int TID_WIDTH         = NOC_TID_W,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int BUFFER_DEPTH      = 2,
  localparam int DEST_WIDTH       = TDEST_WIDTH + TID_WIDTH,
  localparam int CW               = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                   clk_noc,
  input  logic                   rst_noc,
  input  logic                   axis_in_tvalid,
  output logic                   axis_in_tready,
  input  logic                   axis_in_tlast,
  input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
  input  logic [TID_WIDTH-1:0]   axis_in_tid,
  input  logic [TDEST_WIDTH-1:0] axis_in_tdest,
  output logic [TDATA_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in,
  output logic [CW-1:0]          credit_count,
  output logic                   proto_err,
  output logic                   credit_err
);

  localparam logic [CW-1:0] CRED_MAX = CW'(FLIT_BUFFER_DEPTH);

  flit_t                 in_flit, head;
  logic                  fifo_full, fifo_empty;
  logic                  accept, launch;
  logic [DEST_WIDTH-1:0] beat_dest, pkt_dest, pkt_dest_nxt;
  logic                  proto_hit;
  pkt_state_e            state, state_nxt;

  // Ready comes only from registered FIFO state; held low while in reset.
  assign axis_in_tready = !fifo_full && !rst_noc;
  assign accept         = axis_in_tvalid && axis_in_tready;
  assign launch         = !fifo_empty && (credit_count != '0);
  assign beat_dest      = {axis_in_tid, axis_in_tdest};
  assign in_flit        = '{data: axis_in_tdata, dest: beat_dest, is_tail: axis_in_tlast};

  flit_fifo #(
    .WIDTH ($bits(flit_t)),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk   (clk_noc),
    .rst   (rst_noc),
    .push  (accept),
    .din   (in_flit),
    .pop   (launch),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Launch register: strobe for one cycle, payload holds between launches.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= launch;
      if (launch) begin
        data_out    <= head.data;
        dest_out    <= head.dest;
        is_tail_out <= head.is_tail;
      end
    end
  end

  // Credit counter: a launch spends one, a returned credit adds one; a return
  // with the counter already full is an overflow and is flagged, not counted.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      credit_count <= CRED_MAX;
      credit_err   <= 1'b0;
    end else begin
      case ({launch, credit_in})
        2'b10:   credit_count <= credit_count - CW'(1);
        2'b01: begin
          if (credit_count == CRED_MAX) credit_err   <= 1'b1;
          else                          credit_count <= credit_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Packet framing next-state: latch the route on the head beat, compare the
  // body beats against it, return to IDLE on tlast.
  always_comb begin
    state_nxt    = state;
    pkt_dest_nxt = pkt_dest;
    proto_hit    = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!axis_in_tlast) begin
            state_nxt    = IN_PKT;
            pkt_dest_nxt = beat_dest;
          end
        end
        IN_PKT: begin
          proto_hit = (beat_dest != pkt_dest);
          if (axis_in_tlast) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Packet framing state register; protocol error is sticky until reset.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state     <= IDLE;
      pkt_dest  <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pkt_dest  <= pkt_dest_nxt;
      proto_err <= proto_err | proto_hit;
    end
  end

endmodule

// File: tb/tb_axis_flit_injector.sv
// Bench for axis_flit_injector: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axis_flit_injector;

  logic        clk_noc = 1'b0;
  logic        rst_noc = 1'b1;
  logic        tvalid = 1'b0, tlast = 1'b0, credit_in = 1'b0;
  logic [31:0] tdata = '0;
  logic [1:0]  tid = '0;
  logic [3:0]  tdest = '0;
  logic        tready, is_tail_out, send_out, proto_err, credit_err;
  logic [31:0] data_out;
  logic [5:0]  dest_out;
  logic [3:0]  credit_count;

  axis_flit_injector dut (
    .clk_noc        (clk_noc),
    .rst_noc        (rst_noc),
    .axis_in_tvalid (tvalid),
    .axis_in_tready (tready),
    .axis_in_tlast  (tlast),
    .axis_in_tdata  (tdata),
    .axis_in_tid    (tid),
    .axis_in_tdest  (tdest),
    .data_out       (data_out),
    .dest_out       (dest_out),
    .is_tail_out    (is_tail_out),
    .send_out       (send_out),
    .credit_in      (credit_in),
    .credit_count   (credit_count),
    .proto_err      (proto_err),
    .credit_err     (credit_err)
  );

  always #5 clk_noc = ~clk_noc;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] d;
    logic [5:0]  dst;
    logic        t;
  } mflit_t;

  mflit_t      mq[$];
  int          m_cred = 8;
  bit          m_send = 0, m_tail = 0, m_perr = 0, m_cerr = 0, m_inpkt = 0;
  logic [31:0] m_data = '0;
  logic [5:0]  m_dest = '0, m_pdest = '0;

  always @(posedge clk_noc or posedge rst_noc) begin
    bit     m_launch, m_acc;
    mflit_t f;
    if (rst_noc) begin
      mq.delete();
      m_cred = 8; m_send = 0; m_data = '0; m_dest = '0; m_tail = 0;
      m_perr = 0; m_cerr = 0; m_inpkt = 0; m_pdest = '0;
    end else begin
      m_launch = (mq.size() > 0) && (m_cred > 0);
      m_acc    = tvalid && (mq.size() < 2);
      m_send   = m_launch;
      if (m_launch) begin
        f = mq.pop_front();
        m_data = f.d; m_dest = f.dst; m_tail = f.t;
      end
      if (credit_in && !m_launch) begin
        if (m_cred == 8) m_cerr = 1;
        else m_cred++;
      end else if (m_launch && !credit_in) begin
        m_cred--;
      end
      if (m_acc) begin
        f.d = tdata; f.dst = {tid, tdest}; f.t = tlast;
        mq.push_back(f);
        if (m_inpkt) begin
          if (f.dst != m_pdest) m_perr = 1;
          if (tlast) m_inpkt = 0;
        end else if (!tlast) begin
          m_inpkt = 1;
          m_pdest = f.dst;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int         send_cnt = 0;
  logic [5:0] sent_dest[$];

  always @(negedge clk_noc) begin
    check("tready",       tready,       (!rst_noc && mq.size() < 2));
    check("send_out",     send_out,     m_send);
    check("data_out",     data_out,     m_data);
    check("dest_out",     dest_out,     m_dest);
    check("is_tail_out",  is_tail_out,  m_tail);
    check("credit_count", credit_count, m_cred);
    check("proto_err",    proto_err,    m_perr);
    check("credit_err",   credit_err,   m_cerr);
    if (send_out) begin
      send_cnt++;
      sent_dest.push_back(dest_out);
    end
  end

  // ---------------- stimulus ----------------
  // Present a beat from a negedge, wait for ready, return at the negedge after acceptance.
  task automatic push(input logic [31:0] d, input logic [1:0] id, input logic [3:0] dst,
                      input logic last);
    int n = 0;
    tvalid = 1'b1; tdata = d; tid = id; tdest = dst; tlast = last;
    while (!tready && n < 50) begin
      @(negedge clk_noc);
      n++;
    end
    if (!tready) check("push_timeout", 1'b0, 1'b1);
    @(negedge clk_noc);
    tvalid = 1'b0;
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk_noc);
    #1;
    check("rst_tready",  tready,       1'b0);
    check("rst_send",    send_out,     1'b0);
    check("rst_credits", credit_count, 4'd8);
    check("rst_data",    data_out,     32'h0);
    #1 rst_noc = 1'b0;
    #1 check("rel_tready", tready, 1'b1);
    @(negedge clk_noc);

    // Single-flit packet: one cycle of latency through the register stage.
    push(32'hDEADBEEF, 2'd1, 4'd5, 1'b1);
    @(negedge clk_noc);
    check("t1_send",    send_out,     1'b1);
    check("t1_data",    data_out,     32'hDEADBEEF);
    check("t1_dest",    dest_out,     6'h15);
    check("t1_tail",    is_tail_out,  1'b1);
    check("t1_credits", credit_count, 4'd7);
    @(negedge clk_noc);
    check("t1_strobe",  send_out,     1'b0);
    check("t1_hold",    dest_out,     6'h15);

    // Credit return up to the limit, then one too many.
    credit_in = 1'b1; @(negedge clk_noc); credit_in = 1'b0;
    check("t2_credits", credit_count, 4'd8);
    check("t2_noerr",   credit_err,   1'b0);
    credit_in = 1'b1; @(negedge clk_noc); credit_in = 1'b0;
    check("t2_err",     credit_err,   1'b1);
    check("t2_sat",     credit_count, 4'd8);

    // Ten beats with no credit return: eight go out, FIFO fills.
    #1 base = send_cnt;
    for (int i = 0; i < 10; i++) push(32'h1000 + i, 2'd0, 4'd3, 1'b1);
    repeat (3) @(negedge clk_noc);
    #1;
    check("t3_sends",   send_cnt - base, 8);
    check("t3_credits", credit_count,    4'd0);
    check("t3_tready",  tready,          1'b0);
    @(negedge clk_noc);
    credit_in = 1'b1; @(negedge clk_noc); credit_in = 1'b0;
    @(negedge clk_noc);
    check("t3_extra_send", send_out, 1'b1);
    check("t3_extra_data", data_out, 32'h1008);

    // Bring credits to 3 (one credit overlaps the last buffered launch).
    credit_in = 1'b1;
    repeat (4) @(negedge clk_noc);
    credit_in = 1'b0;
    check("t4_pre", credit_count, 4'd3);
    push(32'h2222, 2'd0, 4'd1, 1'b1);
    credit_in = 1'b1; @(negedge clk_noc); credit_in = 1'b0;
    check("t4_send",    send_out,     1'b1);
    check("t4_credits", credit_count, 4'd3);

    // Four-beat packet whose third beat changes tdest.
    credit_in = 1'b1;
    repeat (5) @(negedge clk_noc);
    credit_in = 1'b0;
    check("t5_credits", credit_count, 4'd8);
    check("t5_cerr",    credit_err,   1'b1);
    #1 base = send_cnt;
    push(32'hA0, 2'd0, 4'd5, 1'b0);
    push(32'hA1, 2'd0, 4'd5, 1'b0);
    push(32'hA2, 2'd0, 4'd6, 1'b0);
    push(32'hA3, 2'd0, 4'd5, 1'b1);
    repeat (3) @(negedge clk_noc);
    #1;
    check("t5_perr",  proto_err,       1'b1);
    check("t5_sends", send_cnt - base, 4);
    if (sent_dest.size() >= base + 4) begin
      check("t5_dest3", sent_dest[base+2], 6'h06);
      check("t5_dest4", sent_dest[base+3], 6'h05);
    end else begin
      check("t5_sent_log", sent_dest.size(), base + 4);
    end

    // Reset with a partial packet buffered and no credits left.
    for (int i = 0; i < 4; i++) push(32'h3000 + i, 2'd3, 4'd2, 1'b1);
    push(32'h4000, 2'd1, 4'd7, 1'b0);
    push(32'h4001, 2'd1, 4'd7, 1'b0);
    #1;
    check("t6_full",    tready,       1'b0);
    check("t6_credits", credit_count, 4'd0);
    #1 rst_noc = 1'b1;
    #1;
    check("t6_rst_tready",  tready,       1'b0);
    check("t6_rst_send",    send_out,     1'b0);
    check("t6_rst_credits", credit_count, 4'd8);
    check("t6_rst_perr",    proto_err,    1'b0);
    check("t6_rst_cerr",    credit_err,   1'b0);
    check("t6_rst_dest",    dest_out,     6'h00);
    repeat (2) @(negedge clk_noc);
    #2 rst_noc = 1'b0;
    #1 check("t6_rel_tready", tready, 1'b1);
    base = send_cnt;
    repeat (5) @(negedge clk_noc);
    #1;
    check("t6_no_send", send_cnt - base, 0);
    check("t6_credits_after", credit_count, 4'd8);
    push(32'hCAFE, 2'd2, 4'd9, 1'b1);
    @(negedge clk_noc);
    check("t6_post_send", send_out,  1'b1);
    check("t6_post_dest", dest_out,  6'h29);
    check("t6_post_perr", proto_err, 1'b0);

    repeat (3) @(negedge clk_noc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
